// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, bridge FSM state types and the window decoder.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_PORT, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_PORT, W_RESP} wr_state_e;

    // Unsigned wrap-around subtraction folds both window bounds into one compare.
    function automatic logic [1:0] addr_decode(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input logic [31:0] size);
        logic [31:0] offset;
        offset = addr - base;
        if (offset >= size)
            return RESP_DECERR;
        else if (addr[1:0] != 2'b00)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_uart_bridge.sv
// AXI4-Lite slave that turns bus reads/writes into single-cycle serial port strobes.
module axil_uart_bridge
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE = 32'ha00003f8,
    parameter logic [31:0] SIZE = 32'd8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] uart_raddr,
    input  logic [31:0] uart_rdata,
    output logic        uart_rvalid,
    output logic [31:0] uart_waddr,
    output logic [31:0] uart_wdata,
    output logic        uart_wvalid
);

    // ---------------- read path ----------------
    rd_state_e   r_state, r_next;
    logic [31:0] raddr_q;
    logic        ar_hs;
    logic [1:0]  ar_resp;

    assign ar_hs   = arvalid && arready;
    assign ar_resp = addr_decode(araddr, BASE, SIZE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next      = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        uart_rvalid = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = reset;
                if (ar_hs) r_next = (ar_resp == RESP_OKAY) ? R_PORT : R_RESP;
            end
            R_PORT: begin
                uart_rvalid = 1'b1;
                r_next      = R_RESP;
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            raddr_q <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                raddr_q <= araddr;
                if (ar_resp != RESP_OKAY) begin
                    rdata <= '0;
                    rresp <= ar_resp;
                end
            end
            // Port read data is combinational, so sample it during the strobe cycle.
            if (r_state == R_PORT) begin
                rdata <= uart_rdata;
                rresp <= RESP_OKAY;
            end
        end
    end

    assign uart_raddr = raddr_q;

    // ---------------- write path ----------------
    wr_state_e   w_state, w_next;
    logic [31:0] waddr_q, wdata_q;
    logic        wlane0_q;
    logic        aw_done, w_done;
    logic        aw_hs, w_hs, go;
    logic [31:0] eff_addr;
    logic        eff_lane0;
    logic [1:0]  w_dec, w_resp;
    logic        unused_wstrb;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Decode in the cycle the second channel lands, using whichever half is still on the bus.
    assign eff_addr  = aw_done ? waddr_q  : awaddr;
    assign eff_lane0 = w_done  ? wlane0_q : wstrb[0];
    assign w_dec     = addr_decode(eff_addr, BASE, SIZE);
    assign w_resp    = (w_dec != RESP_OKAY) ? w_dec :
                       (!eff_lane0 ? RESP_SLVERR : RESP_OKAY);
    assign go        = (w_state == W_IDLE) && (aw_done || aw_hs) && (w_done || w_hs);

    // The port only consumes byte lane 0.
    assign unused_wstrb = ^wstrb[3:1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        uart_wvalid = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = reset && !aw_done;
                wready  = reset && !w_done;
                if (go) w_next = (w_resp == RESP_OKAY) ? W_PORT : W_RESP;
            end
            W_PORT: begin
                uart_wvalid = 1'b1;
                w_next      = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            waddr_q  <= '0;
            wdata_q  <= '0;
            wlane0_q <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                waddr_q <= awaddr;
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                wdata_q  <= wdata;
                wlane0_q <= wstrb[0];
                w_done   <= 1'b1;
            end
            if (go) bresp <= w_resp;
            if (w_state == W_RESP && bready) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    assign uart_waddr = waddr_q;
    assign uart_wdata = wdata_q;

endmodule

// File: tb/tb_axil_uart_bridge.sv
// Directed bench for axil_uart_bridge with a small serial port receive/transmit model.
module tb_axil_uart_bridge;

    localparam logic [31:0] DATA_REG = 32'ha00003f8;

    logic        clock, reset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [31:0] uart_raddr, uart_rdata, uart_waddr, uart_wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic        uart_rvalid, uart_wvalid;

    axil_uart_bridge dut (
        .clock(clock), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .uart_raddr(uart_raddr), .uart_rdata(uart_rdata), .uart_rvalid(uart_rvalid),
        .uart_waddr(uart_waddr), .uart_wdata(uart_wdata), .uart_wvalid(uart_wvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Port model: receive FIFO preloaded, popped on a strobe at the data register.
    logic [7:0]  fifo [0:7];
    int          rd_ptr = 0;
    int          rd_strobes = 0;
    int          wr_strobes = 0;
    logic [31:0] last_wdata = '0;

    initial begin
        fifo[0] = 8'h41; fifo[1] = 8'h7e; fifo[2] = 8'h99; fifo[3] = 8'h00;
        fifo[4] = 8'h00; fifo[5] = 8'h00; fifo[6] = 8'h00; fifo[7] = 8'h00;
    end

    assign uart_rdata = (uart_raddr == DATA_REG) ? {24'h0, fifo[rd_ptr % 8]} : 32'h0;

    always @(posedge clock) begin
        if (uart_rvalid) begin
            rd_strobes <= rd_strobes + 1;
            if (uart_raddr == DATA_REG) rd_ptr <= rd_ptr + 1;
        end
        if (uart_wvalid) begin
            wr_strobes <= wr_strobes + 1;
            last_wdata <= uart_wdata;
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int rs0, ws0;

    initial begin
        reset = 1'b0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        #12;
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready",  {31'b0, wready},  32'd0);
        check("rst_valids",  {28'b0, rvalid, bvalid, uart_rvalid, uart_wvalid}, 32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_resps",   {28'b0, bresp, rresp}, 32'd0);
        check("rst_uaddr",   uart_raddr | uart_waddr | uart_wdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Legal read of the data register.
        check("idle_arready", {31'b0, arready}, 32'd1);
        araddr = DATA_REG; arvalid = 1;
        tick();
        arvalid = 0;
        check("rd_strobe",   {31'b0, uart_rvalid}, 32'd1);
        check("rd_raddr",    uart_raddr, DATA_REG);
        check("rd_no_rv_t1", {31'b0, rvalid}, 32'd0);
        tick();
        check("rd_rvalid",   {31'b0, rvalid}, 32'd1);
        check("rd_rdata",    rdata, 32'h41);
        check("rd_rresp",    {30'b0, rresp}, 32'd0);
        check("rd_strobe_off", {31'b0, uart_rvalid}, 32'd0);
        rready = 1;
        tick();
        rready = 0;
        check("rd_done",     {31'b0, rvalid}, 32'd0);
        check("rd_ptr",      rd_ptr, 32'd1);
        check("rd_strobes",  rd_strobes, 32'd1);

        // W leads AW by two cycles.
        wdata = 32'h5a; wstrb = 4'h1; wvalid = 1;
        tick();
        wvalid = 0;
        check("w_captured",  {30'b0, wready, awready}, 32'b01);
        tick();
        awaddr = DATA_REG; awvalid = 1;
        tick();
        awvalid = 0;
        check("wr_strobe",   {31'b0, uart_wvalid}, 32'd1);
        check("wr_wdata",    {24'b0, uart_wdata[7:0]}, 32'h5a);
        check("wr_waddr",    uart_waddr, DATA_REG);
        tick();
        check("wr_bvalid",   {31'b0, bvalid}, 32'd1);
        check("wr_bresp",    {30'b0, bresp}, 32'd0);
        bready = 1;
        tick();
        bready = 0;
        check("wr_done",     {31'b0, bvalid}, 32'd0);
        check("wr_strobes",  wr_strobes, 32'd1);
        check("wr_last",     last_wdata, 32'h5a);

        // Read outside the window.
        araddr = 32'h80000000; arvalid = 1;
        tick();
        arvalid = 0;
        check("dec_rvalid",  {31'b0, rvalid}, 32'd1);
        check("dec_rresp",   {30'b0, rresp}, 32'd3);
        check("dec_rdata",   rdata, 32'd0);
        check("dec_nostrobe", {31'b0, uart_rvalid}, 32'd0);
        rready = 1;
        tick();
        rready = 0;

        // Misaligned write, AW and W together.
        awaddr = 32'ha00003f9; awvalid = 1; wdata = 32'h11; wstrb = 4'h1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        check("mis_bvalid",  {31'b0, bvalid}, 32'd1);
        check("mis_bresp",   {30'b0, bresp}, 32'd2);
        check("mis_nostrobe", {31'b0, uart_wvalid}, 32'd0);
        bready = 1;
        tick();
        bready = 0;

        // Byte lane 0 not enabled.
        awaddr = DATA_REG; awvalid = 1; wdata = 32'h2200; wstrb = 4'h2; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        check("strb_bresp",  {30'b0, bresp}, 32'd2);
        check("strb_bvalid", {31'b0, bvalid}, 32'd1);
        bready = 1;
        tick();
        bready = 0;
        check("err_wstrobes", wr_strobes, 32'd1);
        check("err_rstrobes", rd_strobes, 32'd1);

        // Simultaneous read and write; read response stalled while write completes.
        araddr = DATA_REG; arvalid = 1;
        awaddr = DATA_REG; awvalid = 1; wdata = 32'h33; wstrb = 4'hf; wvalid = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        check("sim_strobes", {30'b0, uart_rvalid, uart_wvalid}, 32'b11);
        bready = 1;
        tick();
        check("stall_bvalid", {31'b0, bvalid}, 32'd1);
        check("stall_rdata0", rdata, 32'h7e);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_hold", {rvalid, 21'b0, rresp, rdata[7:0]}, {1'b1, 21'b0, 2'b00, 8'h7e});
        end
        bready = 0;
        check("stall_bdone",   {31'b0, bvalid}, 32'd0);
        check("stall_rstrobes", rd_strobes, 32'd2);
        check("stall_wstrobes", wr_strobes, 32'd2);
        check("stall_wdata",   last_wdata, 32'h33);
        rready = 1;
        tick();
        rready = 0;
        check("stall_rdone",   {31'b0, rvalid}, 32'd0);

        // Async reset while both FSMs sit in their port states.
        rs0 = rd_strobes; ws0 = wr_strobes;
        araddr = DATA_REG; arvalid = 1;
        awaddr = DATA_REG; awvalid = 1; wdata = 32'h44; wstrb = 4'h1; wvalid = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        check("pre_rst_strobes", {30'b0, uart_rvalid, uart_wvalid}, 32'b11);
        #2;
        reset = 1'b0;
        #1;
        check("arst_strobes", {30'b0, uart_rvalid, uart_wvalid}, 32'd0);
        check("arst_valids",  {29'b0, rvalid, bvalid, arready}, 32'd0);
        check("arst_ready",   {30'b0, awready, wready}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        check("arst_rcount", rd_strobes, rs0);
        check("arst_wcount", wr_strobes, ws0);
        check("arst_ptr",    rd_ptr, 32'd2);

        araddr = DATA_REG; arvalid = 1;
        awaddr = DATA_REG; awvalid = 1; wdata = 32'hc3; wstrb = 4'h1; wvalid = 1;
        tick();
        arvalid = 0; awvalid = 0; wvalid = 0;
        check("post_strobes", {30'b0, uart_rvalid, uart_wvalid}, 32'b11);
        rready = 1; bready = 1;
        tick();
        check("post_resp",   {30'b0, rvalid, bvalid}, 32'b11);
        check("post_rdata",  rdata, 32'h99);
        tick();
        rready = 0; bready = 0;
        check("post_idle",   {30'b0, rvalid, bvalid}, 32'd0);
        check("post_rcount", rd_strobes, rs0 + 1);
        check("post_wcount", wr_strobes, ws0 + 1);
        check("post_wdata",  last_wdata, 32'hc3);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
